// File: rtl/swu_pkg.sv
// Shared types and width helpers for the sliding-window-unit bank scheduler.
package swu_pkg;

    localparam int unsigned DEF_BUFFER_DEPTH = 20;
    localparam int unsigned DEF_MMV_IN       = 2;
    localparam int unsigned DEF_WPB          = DEF_BUFFER_DEPTH / DEF_MMV_IN;
    localparam int unsigned DESC_LEN_W       = 16;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [DESC_LEN_W-1:0] len;
        logic                  last;
    } bank_desc_t;

    function automatic int unsigned wpb_of(input int unsigned depth, input int unsigned mmv);
        return depth / mmv;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/swu_desc_fifo.sv
// Closed-bank descriptor FIFO; head is a registered copy of the oldest entry.
module swu_desc_fifo
    import swu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       clear,
    input  logic                       push,
    input  bank_desc_t                 push_data,
    input  logic                       pop,
    output bank_desc_t                 head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = width_of(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    bank_desc_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Head is updated with the post-cycle oldest entry so it stays a flop output.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                if (count > CW'(1)) begin
                    head <= mem[ptr_inc(rd_ptr)];
                end else if (push) begin
                    head <= push_data;
                end else begin
                    head <= '0;
                end
            end else if ((count == '0) && push) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/swu_bank_scheduler.sv
// Write-side bank/address sequencer and closed-bank handoff for the SWU input buffer.
module swu_bank_scheduler
    import swu_pkg::*;
#(
    parameter int unsigned NWORDS       = 1024,
    parameter int unsigned BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter int unsigned MMV_IN       = DEF_MMV_IN,
    parameter int unsigned NBANKS       = 2
) (
    input  logic                                                  aclk,
    input  logic                                                  aresetn,
    input  logic                                                  s_valid,
    output logic                                                  s_ready,
    output logic                                                  wr_en,
    output logic [width_of(NBANKS)-1:0]                           wr_bank,
    output logic [width_of(wpb_of(BUFFER_DEPTH, MMV_IN))-1:0]     wr_addr,
    output logic                                                  rd_avail,
    output logic [width_of(NBANKS)-1:0]                           rd_bank,
    output logic [$clog2(wpb_of(BUFFER_DEPTH, MMV_IN)):0]         rd_len,
    output logic                                                  rd_last,
    input  logic                                                  rd_done,
    input  logic                                                  restart,
    output logic                                                  frame_done,
    output logic [$clog2(NBANKS+1)-1:0]                           occupancy
);

    localparam int unsigned WPB = wpb_of(BUFFER_DEPTH, MMV_IN);
    localparam int unsigned BW  = width_of(NBANKS);
    localparam int unsigned AW  = width_of(WPB);
    localparam int unsigned LW  = $clog2(WPB) + 1;
    localparam int unsigned OW  = $clog2(NBANKS + 1);
    localparam int unsigned FW  = width_of(NWORDS);

    wr_state_t     state_q;
    wr_state_t     state_d;
    logic [FW-1:0] frame_cnt;
    logic          last_word_c;
    logic          close_c;
    logic          pop_c;
    bank_desc_t    push_desc;
    bank_desc_t    head;
    logic          len_unused;

    assign s_ready     = (state_q == FILL);
    assign wr_en       = s_valid & s_ready;
    assign rd_avail    = (occupancy != '0);
    assign pop_c       = rd_done & rd_avail;
    assign last_word_c = (frame_cnt == FW'(NWORDS - 1));
    assign close_c     = wr_en & ((wr_addr == AW'(WPB - 1)) | last_word_c);

    assign push_desc.len  = DESC_LEN_W'(wr_addr) + DESC_LEN_W'(1);
    assign push_desc.last = last_word_c;

    assign rd_len     = head.len[LW-1:0];
    assign rd_last    = head.last;
    assign len_unused = |(head.len >> LW);

    swu_desc_fifo #(
        .DEPTH (NBANKS)
    ) u_desc_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (restart),
        .push      (close_c),
        .push_data (push_desc),
        .pop       (pop_c),
        .head      (head),
        .count     (occupancy)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall only when this close fills the last free bank and nothing is released alongside it.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: if (close_c && !pop_c && (occupancy == OW'(NBANKS - 1))) state_d = WAIT;
                WAIT: if (pop_c) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_bank    <= '0;
            wr_addr    <= '0;
            frame_cnt  <= '0;
            rd_bank    <= '0;
            frame_done <= 1'b0;
        end else if (restart) begin
            wr_bank    <= '0;
            wr_addr    <= '0;
            frame_cnt  <= '0;
            rd_bank    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (wr_en) begin
                if (close_c) begin
                    wr_addr <= '0;
                    wr_bank <= (wr_bank == BW'(NBANKS - 1)) ? '0 : wr_bank + BW'(1);
                end else begin
                    wr_addr <= wr_addr + AW'(1);
                end
                frame_cnt <= last_word_c ? '0 : frame_cnt + FW'(1);
            end
            if (pop_c) begin
                rd_bank <= (rd_bank == BW'(NBANKS - 1)) ? '0 : rd_bank + BW'(1);
            end
            frame_done <= pop_c & head.last;
        end
    end

endmodule

// File: tb/tb_swu_bank_scheduler.sv
// Scoreboard bench for swu_bank_scheduler with NWORDS=25, WPB=10, NBANKS=2.
module tb_swu_bank_scheduler;

    localparam int unsigned NW  = 25;
    localparam int unsigned BD  = 20;
    localparam int unsigned MMV = 2;
    localparam int unsigned NB  = 2;
    localparam int unsigned BW  = 1;
    localparam int unsigned AW  = 4;
    localparam int unsigned LW  = 5;
    localparam int unsigned OW  = 2;

    logic          aclk;
    logic          aresetn;
    logic          s_valid;
    logic          s_ready;
    logic          wr_en;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_avail;
    logic [BW-1:0] rd_bank;
    logic [LW-1:0] rd_len;
    logic          rd_last;
    logic          rd_done;
    logic          restart;
    logic          frame_done;
    logic [OW-1:0] occupancy;

    int n_vec = 0;
    int n_err = 0;
    int wq_bank[$];
    int wq_addr[$];
    int dq_bank[$];
    int dq_len[$];
    int dq_last[$];

    // Every output packed for reset/restart checks (s_valid is held 0 there).
    logic [17:0] clr_vec;
    localparam logic [17:0] CLR_EXP = {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0};
    assign clr_vec = {s_ready, wr_en, wr_bank, wr_addr, rd_avail, rd_bank, rd_len, rd_last,
                      occupancy, frame_done};

    swu_bank_scheduler #(
        .NWORDS       (NW),
        .BUFFER_DEPTH (BD),
        .MMV_IN       (MMV),
        .NBANKS       (NB)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .rd_avail   (rd_avail),
        .rd_bank    (rd_bank),
        .rd_len     (rd_len),
        .rd_last    (rd_last),
        .rd_done    (rd_done),
        .restart    (restart),
        .frame_done (frame_done),
        .occupancy  (occupancy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic expect_writes(input int bank, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wq_bank.push_back(bank);
            wq_addr.push_back(first + i);
        end
    endtask

    task automatic expect_desc(input int bank, input int len, input int last);
        dq_bank.push_back(bank);
        dq_len.push_back(len);
        dq_last.push_back(last);
    endtask

    task automatic drop_descs();
        dq_bank.delete();
        dq_len.delete();
        dq_last.delete();
    endtask

    // One clock: inputs were set at the preceding falling edge; scoreboard pops happen before the rising edge.
    task automatic step();
        int eb;
        int ea;
        int el;
        int et;
        #1;
        if (wr_en) begin
            n_vec++;
            if (wq_bank.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got bank=%0d addr=%0d, expected no write", wr_bank, wr_addr);
            end else begin
                eb = wq_bank.pop_front();
                ea = wq_addr.pop_front();
                if (wr_bank !== BW'(eb) || wr_addr !== AW'(ea)) begin
                    n_err++;
                    $display("FAIL write_slot: got bank=%0d addr=%0d, expected bank=%0d addr=%0d",
                             wr_bank, wr_addr, eb, ea);
                end
            end
        end
        if (rd_done && rd_avail) begin
            n_vec++;
            if (dq_bank.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_desc: got bank=%0d len=%0d last=%0d, expected none",
                         rd_bank, rd_len, rd_last);
            end else begin
                eb = dq_bank.pop_front();
                el = dq_len.pop_front();
                et = dq_last.pop_front();
                if (rd_bank !== BW'(eb) || rd_len !== LW'(el) || rd_last !== 1'(et)) begin
                    n_err++;
                    $display("FAIL rd_desc: got bank=%0d len=%0d last=%0d, expected bank=%0d len=%0d last=%0d",
                             rd_bank, rd_len, rd_last, eb, el, et);
                end
            end
        end
        @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_valid = 1'b0;
        rd_done = 1'b0;
        restart = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        step();
        n_vec++;
        if (clr_vec !== CLR_EXP) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", clr_vec, CLR_EXP);
        end
    endtask

    task automatic test_fill();
        expect_writes(0, 0, 10);
        expect_writes(1, 0, 10);
        expect_desc(0, 10, 0);
        expect_desc(1, 10, 0);
        expect_desc(0, 5, 1);
        s_valid = 1'b1;
        repeat (20) step();
        n_vec++;
        if ({s_ready, occupancy, rd_avail, rd_bank, rd_len, rd_last} !== {1'b0, 2'd2, 1'b1, 1'b0, 5'd10, 1'b0}) begin
            n_err++;
            $display("FAIL fill_full: got rdy=%0d occ=%0d av=%0d bank=%0d len=%0d last=%0d, expected 0 2 1 0 10 0",
                     s_ready, occupancy, rd_avail, rd_bank, rd_len, rd_last);
        end
        repeat (3) step();
        n_vec++;
        if (occupancy !== 2'd2 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_stall: got occ=%0d rdy=%0d, expected occ=2 rdy=0", occupancy, s_ready);
        end
    endtask

    task automatic test_release();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        n_vec++;
        if ({rd_bank, s_ready, occupancy, rd_len, rd_last} !== {1'b1, 1'b1, 2'd1, 5'd10, 1'b0}) begin
            n_err++;
            $display("FAIL release_first: got bank=%0d rdy=%0d occ=%0d len=%0d last=%0d, expected 1 1 1 10 0",
                     rd_bank, s_ready, occupancy, rd_len, rd_last);
        end
        expect_writes(0, 0, 5);
        repeat (5) step();
        s_valid = 1'b0;
        n_vec++;
        if ({occupancy, s_ready, rd_bank} !== {2'd2, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL partial_close: got occ=%0d rdy=%0d bank=%0d, expected 2 0 1", occupancy, s_ready, rd_bank);
        end
        rd_done = 1'b1;
        step();
        n_vec++;
        if ({rd_bank, rd_len, rd_last, frame_done, occupancy} !== {1'b0, 5'd5, 1'b1, 1'b0, 2'd1}) begin
            n_err++;
            $display("FAIL partial_head: got bank=%0d len=%0d last=%0d fd=%0d occ=%0d, expected 0 5 1 0 1",
                     rd_bank, rd_len, rd_last, frame_done, occupancy);
        end
        step();
        rd_done = 1'b0;
        n_vec++;
        if ({frame_done, occupancy, rd_avail, rd_bank} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL frame_done_pulse: got fd=%0d occ=%0d av=%0d bank=%0d, expected 1 0 0 1",
                     frame_done, occupancy, rd_avail, rd_bank);
        end
        expect_writes(1, 0, 1);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL frame_done_once: got %0d expected 0", frame_done);
        end
    endtask

    task automatic test_back_to_back();
        expect_writes(1, 1, 9);
        expect_writes(0, 0, 10);
        expect_writes(1, 0, 1);
        expect_desc(1, 10, 0);
        expect_desc(0, 10, 0);
        s_valid = 1'b1;
        repeat (18) step();
        n_vec++;
        if ({occupancy, rd_bank, wr_bank, wr_addr} !== {2'd1, 1'b1, 1'b0, 4'd9}) begin
            n_err++;
            $display("FAIL pre_overlap: got occ=%0d rbank=%0d wbank=%0d waddr=%0d, expected 1 1 0 9",
                     occupancy, rd_bank, wr_bank, wr_addr);
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        n_vec++;
        if ({occupancy, s_ready, rd_bank, rd_len, rd_last} !== {2'd1, 1'b1, 1'b0, 5'd10, 1'b0}) begin
            n_err++;
            $display("FAIL close_and_pop: got occ=%0d rdy=%0d bank=%0d len=%0d last=%0d, expected 1 1 0 10 0",
                     occupancy, s_ready, rd_bank, rd_len, rd_last);
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic test_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        drop_descs();
        expect_writes(0, 0, 10);
        expect_writes(1, 0, 3);
        expect_desc(0, 10, 0);
        s_valid = 1'b1;
        repeat (13) step();
        s_valid = 1'b0;
        n_vec++;
        if ({occupancy, wr_bank, wr_addr} !== {2'd1, 1'b1, 4'd3}) begin
            n_err++;
            $display("FAIL pre_restart: got occ=%0d bank=%0d addr=%0d, expected 1 1 3", occupancy, wr_bank, wr_addr);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        drop_descs();
        n_vec++;
        if (clr_vec !== CLR_EXP) begin
            n_err++;
            $display("FAIL restart_state: got %h expected %h", clr_vec, CLR_EXP);
        end
        expect_writes(0, 0, 1);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        expect_writes(0, 1, 9);
        expect_writes(1, 0, 2);
        expect_desc(0, 10, 0);
        s_valid = 1'b1;
        repeat (11) step();
        s_valid = 1'b0;
        n_vec++;
        if ({wr_bank, wr_addr, occupancy} !== {1'b1, 4'd2, 2'd1}) begin
            n_err++;
            $display("FAIL pre_async: got bank=%0d addr=%0d occ=%0d, expected 1 2 1", wr_bank, wr_addr, occupancy);
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_vec++;
        if (clr_vec !== CLR_EXP) begin
            n_err++;
            $display("FAIL async_clear: got %h expected %h", clr_vec, CLR_EXP);
        end
        drop_descs();
        @(negedge aclk);
        aresetn = 1'b1;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        n_vec++;
        if ({rd_bank, occupancy, frame_done, s_ready} !== {1'b0, 2'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL spurious_done: got bank=%0d occ=%0d fd=%0d rdy=%0d, expected 0 0 0 1",
                     rd_bank, occupancy, frame_done, s_ready);
        end
        expect_writes(0, 0, 1);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_back_to_back();
        test_restart();
        test_async_reset();
        n_vec++;
        if (wq_bank.size() !== 0) begin
            n_err++;
            $display("FAIL writes_drained: got %0d pending, expected 0", wq_bank.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
